sg_frame_sequencer: RTL and testbench
=====================================

# sg_frame_sequencer

Frame-level controller for the 7-tap Savitzky-Golay smoothing datapath. On `start` it reads one frame of ADC samples from the sample RAM, builds the sliding window and hands one window per handshake to the external filter MAC. It writes each in-order result to the result RAM, then fills the edge positions by replicating the first and last valid results. It sits between the ADC capture buffer and the output buffer, replacing software-style whole-array filtering with a cycle-accurate sequence.

## Interface
- `DATA_SIZE`, 1000, samples per frame; must be ≥ `WINDOW_SIZE`, with an elaboration-time error otherwise.
- `WINDOW_SIZE`, 7, filter taps; must be odd. `H = WINDOW_SIZE/2`.
- `SAMPLE_W`, 8, ADC sample width.
- `RES_W`, 16, filtered result width.
- `ADDR_W`, 10, RAM address width; must satisfy `2**ADDR_W ≥ DATA_SIZE`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle frame request.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  sample RAM read strobe.
- `rd_addr`  out  ADDR_W  sample RAM address.
- `rd_data`  in  SAMPLE_W  sample RAM data, valid the cycle after `rd_en`.
- `win_valid`  out  1  window offer to the MAC.
- `win_ready`  in  1  MAC accepts the window when `win_valid && win_ready`.
- `win_data`  out  WINDOW_SIZE*SAMPLE_W  tap k in bits [k*SAMPLE_W +: SAMPLE_W]; tap 0 is the oldest sample.
- `res_valid`  in  1  MAC result strobe; results arrive in order, with no backpressure and any latency ≥ 1.
- `res_data`  in  RES_W  MAC result.
- `wr_en`  out  1  result RAM write strobe.
- `wr_addr`  out  ADDR_W  result RAM address.
- `wr_data`  out  RES_W  result RAM data.

## Operation
- States: IDLE → FILL → RUN → DRAIN → PAD → DONE → IDLE.
- IDLE: `start` is accepted here only. An accepted `start` clears the counters and enters FILL.
- FILL: the block issues `rd_en` on consecutive cycles for addresses 0 .. WINDOW_SIZE-1. Each returned sample shifts into tap WINDOW_SIZE-1, and older samples move toward tap 0. After the last sample lands, the block enters RUN.
- RUN:
  - `win_valid` stays high, and `win_data` stays frozen, until the window is accepted.
  - On an accept, if windows remain, the block reads the next address in the same cycle and the window shifts when the data returns.
  - Total windows = `DATA_SIZE - WINDOW_SIZE + 1`.
  - After the last window is accepted, the block enters DRAIN.
- DRAIN: the block waits until the outstanding counter (accepted windows minus results received) reaches 0.
- Result capture in RUN and DRAIN: result j is written to `wr_addr = H + j`. Result 0 is latched as `first_res` and the most recent result as `last_res`.
- PAD:
  - Writes `first_res` to addresses 0 .. H-1.
  - Then writes `last_res` to addresses DATA_SIZE-H .. DATA_SIZE-1.
  - One write per cycle, 2H cycles in total.
- DONE: `done` pulses for one cycle, `busy` drops in the same cycle, and the FSM returns to IDLE.
- `start` while busy is ignored and not queued.
- Result width is carried unchanged; the block performs no arithmetic on data.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `win_valid` and `wr_en` are 0. `rd_addr`, `wr_addr`, `wr_data` and `win_data` are 0. The FSM is in IDLE.
- `rst` asserted mid-frame aborts immediately. Outstanding MAC results arriving after reset are ignored.
- The first `rd_en` occurs 1 cycle after the `start` cycle.
- The first `win_valid` occurs at start+WINDOW_SIZE+2.
- With `win_ready` tied high, a window is accepted every 2 cycles:
  - accept at cycle t;
  - `rd_en` at t;
  - data shifts at the end of t+1;
  - `win_valid` is high again at t+2.
- `wr_en`, `wr_addr` and `wr_data` are registered: they appear 1 cycle after the corresponding `res_valid`.
- `done` follows the last PAD write by 1 cycle. Without padding, it follows the last result write by 1 cycle.
- `res_valid` in the same cycle as a window accept: both are counted, and the outstanding counter is unchanged.

## Configuration
- `SG_SEQ_EDGE_PAD_EN` defined:
  - The PAD state exists and the 2H edge writes occur.
  - Edge addresses are always written.
- `SG_SEQ_EDGE_PAD_EN` undefined:
  - PAD is removed and DRAIN goes directly to DONE.
  - Addresses 0 .. H-1 and DATA_SIZE-H .. DATA_SIZE-1 are never written.
  - `first_res` and `last_res` are not implemented.

## Test plan
The bench uses `DATA_SIZE` = 16 and `WINDOW_SIZE` = 7, with sample RAM `mem[i] = i` and a MAC model returning tap 3 after 3 cycles, unless noted.

1. Pad defined, `win_ready` = 1, single `start` → 10 result writes: addresses 3..12 receive 3..12. Addresses 0..2 receive 3 and addresses 13..15 receive 12. Exactly 16 writes, one `done` pulse.
2. `win_ready` held low for 5 cycles on the second window → `win_valid` stays high, `win_data` stays taps 1..7, and no `rd_en` occurs during the stall. Final output is identical to scenario 1.
3. `start` pulsed again in the tenth busy cycle → ignored: one `done` only, no extra reads.
4. `rst` low during RUN after 4 accepts → all outputs 0 on the next sample point. A later `start` re-reads from address 0 and reproduces scenario 1.
5. Pad undefined → only addresses 3..12 are written (10 writes). `done` occurs 1 cycle after the last write.
6. `DATA_SIZE` = 7 → one window. Address 3 receives 3, addresses 0..2 receive 3 and addresses 4..6 receive 3, for 7 writes in total.

Source files
------------

// File: rtl/sg_frame_sequencer.sv
// Frame sequencer for the Savitzky-Golay smoothing datapath: sample RAM -> sliding window -> MAC -> result RAM.
// Define SG_SEQ_EDGE_PAD_EN to replicate the first/last results into the edge addresses.
module sg_frame_sequencer #(
    parameter int DATA_SIZE   = 1000,
    parameter int WINDOW_SIZE = 7,
    parameter int SAMPLE_W    = 8,
    parameter int RES_W       = 16,
    parameter int ADDR_W      = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [ADDR_W-1:0]               rd_addr,
    input  logic [SAMPLE_W-1:0]             rd_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [WINDOW_SIZE*SAMPLE_W-1:0] win_data,
    input  logic                            res_valid,
    input  logic [RES_W-1:0]                res_data,
    output logic                            wr_en,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic [RES_W-1:0]                wr_data
);
    localparam int H    = WINDOW_SIZE / 2;
    localparam int NWIN = DATA_SIZE - WINDOW_SIZE + 1;
    localparam int CW   = ADDR_W + 1;
    localparam int FW   = $clog2(WINDOW_SIZE + 1);

    if (DATA_SIZE < WINDOW_SIZE) begin : g_chk_size
        $error("DATA_SIZE must be >= WINDOW_SIZE");
    end
    if (WINDOW_SIZE % 2 == 0) begin : g_chk_odd
        $error("WINDOW_SIZE must be odd");
    end
    if (2**ADDR_W < DATA_SIZE) begin : g_chk_addr
        $error("ADDR_W too small for DATA_SIZE");
    end

`ifdef SG_SEQ_EDGE_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_PAD, S_DONE} state_t;
    localparam int PW = $clog2(2*H + 1);
    localparam logic [ADDR_W-1:0] PAD_HI_BASE = ADDR_W'(DATA_SIZE - 2*H);
    logic [PW-1:0]    pad_cnt;
    logic [RES_W-1:0] first_res, last_res;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [CW-1:0]     rd_ptr, acc_cnt, out_cnt;
    logic [ADDR_W-1:0] res_cnt;
    logic [FW-1:0]     fill_cnt;
    logic              rd_vld;
    logic [WINDOW_SIZE-1:0][SAMPLE_W-1:0] taps;

    logic accept, last_acc, fill_last, res_take, drained;

    assign accept    = (state == S_RUN) && win_valid && win_ready;
    assign last_acc  = accept && (acc_cnt == CW'(NWIN - 1));
    assign fill_last = (state == S_FILL) && rd_vld && (fill_cnt == FW'(WINDOW_SIZE - 1));
    assign res_take  = res_valid && ((state == S_RUN) || (state == S_DRAIN));
    assign drained   = (state == S_DRAIN) && (out_cnt == '0);

    assign rd_addr  = rd_ptr[ADDR_W-1:0];
    assign win_data = taps;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        // FILL reads back-to-back; RUN reads in the accept cycle while samples remain
        rd_en     = ((state == S_FILL) && (rd_ptr < CW'(WINDOW_SIZE))) ||
                    (accept && (rd_ptr < CW'(DATA_SIZE)));
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FILL;
            end
            S_FILL:  if (fill_last) state_nxt = S_RUN;
            S_RUN:   if (last_acc)  state_nxt = S_DRAIN;
`ifdef SG_SEQ_EDGE_PAD_EN
            S_DRAIN: if (drained)   state_nxt = S_PAD;
            S_PAD:   if (pad_cnt == PW'(2*H)) state_nxt = S_DONE;
`else
            S_DRAIN: if (drained)   state_nxt = S_DONE;
`endif
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // read pointer, window shifter and handshake bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            acc_cnt   <= '0;
            out_cnt   <= '0;
            res_cnt   <= '0;
            fill_cnt  <= '0;
            rd_vld    <= 1'b0;
            taps      <= '0;
            win_valid <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if ((state == S_IDLE) && start) begin
                rd_ptr   <= '0;
                acc_cnt  <= '0;
                out_cnt  <= '0;
                res_cnt  <= '0;
                fill_cnt <= '0;
            end else begin
                if (rd_en)                       rd_ptr   <= rd_ptr + 1'b1;
                if (rd_vld && state == S_FILL)   fill_cnt <= fill_cnt + 1'b1;
                if (accept)                      acc_cnt  <= acc_cnt + 1'b1;
                if (res_take)                    res_cnt  <= res_cnt + 1'b1;
                case ({accept, res_take})
                    2'b10:   out_cnt <= out_cnt + 1'b1;
                    2'b01:   out_cnt <= out_cnt - 1'b1;
                    default: out_cnt <= out_cnt;
                endcase
            end
            if (rd_vld) taps <= {rd_data, taps[WINDOW_SIZE-1:1]};
            if (fill_last || (rd_vld && state == S_RUN)) win_valid <= 1'b1;
            else if (accept)                             win_valid <= 1'b0;
        end
    end

    // result RAM write port: in-order results, then edge replication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef SG_SEQ_EDGE_PAD_EN
            pad_cnt   <= '0;
            first_res <= '0;
            last_res  <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (res_take) begin
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(H) + res_cnt;
                wr_data <= res_data;
            end
`ifdef SG_SEQ_EDGE_PAD_EN
            if (res_take) begin
                if (res_cnt == '0) first_res <= res_data;
                last_res <= res_data;
            end
            // the first pad write issues on the DRAIN exit edge so done lands one cycle after the last write
            if (drained) begin
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= first_res;
                pad_cnt <= PW'(1);
            end else if ((state == S_PAD) && (pad_cnt != PW'(2*H))) begin
                wr_en   <= 1'b1;
                if (pad_cnt < PW'(H)) begin
                    wr_addr <= ADDR_W'(pad_cnt);
                    wr_data <= first_res;
                end else begin
                    wr_addr <= PAD_HI_BASE + ADDR_W'(pad_cnt);
                    wr_data <= last_res;
                end
                pad_cnt <= pad_cnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sg_frame_sequencer.sv
// Directed bench for sg_frame_sequencer: two instances (16- and 7-sample frames), RAM and 3-cycle MAC models.
module tb_sg_frame_sequencer;
    localparam int W = 7, SW = 8, RW = 16, AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start[2], busy[2], done[2], rd_en[2], win_valid[2], win_ready[2];
    logic          res_valid[2], wr_en[2];
    logic [AW-1:0] rd_addr[2], wr_addr[2];
    logic [SW-1:0] rd_data[2];
    logic [W*SW-1:0] win_data[2];
    logic [RW-1:0] res_data[2], wr_data[2];

    sg_frame_sequencer #(.DATA_SIZE(16), .WINDOW_SIZE(W), .SAMPLE_W(SW), .RES_W(RW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_data(win_data[0]),
        .res_valid(res_valid[0]), .res_data(res_data[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]));

    sg_frame_sequencer #(.DATA_SIZE(7), .WINDOW_SIZE(W), .SAMPLE_W(SW), .RES_W(RW), .ADDR_W(AW)) dut7 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_data(win_data[1]),
        .res_valid(res_valid[1]), .res_data(res_data[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]));

    // sample RAM holds mem[i] = i; MAC returns tap 3 three cycles after accept (not reset)
    logic [2:0]    mv[2] = '{3'b0, 3'b0};
    logic [RW-1:0] md[2][3];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) rd_data[i] <= SW'(rd_addr[i]);
            mv[i]    <= {mv[i][1:0], win_valid[i] && win_ready[i]};
            md[i][0] <= RW'(win_data[i][3*SW +: SW]);
            md[i][1] <= md[i][0];
            md[i][2] <= md[i][1];
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            res_valid[i] = mv[i][2];
            res_data[i]  = md[i][2];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nwr[2], nrd[2], ndone[2], last_wr[2], done_cyc[2], first_rd[2], first_wv[2], second_wv[2];
    int wcnt[2][16];
    logic [RW-1:0] wval[2][16];
    bit prev_wv[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                nwr[i]++;
                last_wr[i] = cyc;
                if (wr_addr[i] < 16) begin
                    wcnt[i][wr_addr[i]]++;
                    wval[i][wr_addr[i]] = wr_data[i];
                end
            end
            if (rd_en[i]) begin
                if (nrd[i] == 0) first_rd[i] = cyc;
                nrd[i]++;
            end
            if (done[i]) begin
                ndone[i]++;
                done_cyc[i] = cyc;
            end
            if (win_valid[i] && !prev_wv[i]) begin
                if (first_wv[i] < 0)       first_wv[i] = cyc;
                else if (second_wv[i] < 0) second_wv[i] = cyc;
            end
            prev_wv[i] = win_valid[i];
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_sb(input int i);
        nwr[i] = 0; nrd[i] = 0; ndone[i] = 0; last_wr[i] = -100; done_cyc[i] = 0;
        first_rd[i] = -1; first_wv[i] = -1; second_wv[i] = -1;
        for (int a = 0; a < 16; a++) begin
            wcnt[i][a] = 0;
            wval[i][a] = '0;
        end
    endtask

    task automatic do_start(input int i, output int s);
        @(negedge clk);
        start[i] = 1'b1;
        s = cyc;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            #2;
            if (ndone[i] > 0) break;
        end
        chk({tag, " done seen"}, 64'(ndone[i] > 0), 64'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_idle(input int i, input string tag);
        chk({tag, " busy"}, 64'(busy[i]), 64'd0);
        chk({tag, " done"}, 64'(done[i]), 64'd0);
        chk({tag, " rd_en"}, 64'(rd_en[i]), 64'd0);
        chk({tag, " win_valid"}, 64'(win_valid[i]), 64'd0);
        chk({tag, " wr_en"}, 64'(wr_en[i]), 64'd0);
        chk({tag, " rd_addr"}, 64'(rd_addr[i]), 64'd0);
        chk({tag, " wr_addr"}, 64'(wr_addr[i]), 64'd0);
        chk({tag, " wr_data"}, 64'(wr_data[i]), 64'd0);
        chk({tag, " win_data"}, 64'(win_data[i]), 64'd0);
    endtask

    // first result is sample 3 (H), last is ds-4; edges replicate them when padding is built in
    task automatic check_frame(input int i, input int ds, input string tag);
        bit pad, written;
        int expv;
`ifdef SG_SEQ_EDGE_PAD_EN
        pad = 1'b1;
`else
        pad = 1'b0;
`endif
        chk({tag, " writes"}, 64'(nwr[i]), pad ? 64'(ds) : 64'(ds - 6));
        chk({tag, " dones"}, 64'(ndone[i]), 64'd1);
        chk({tag, " reads"}, 64'(nrd[i]), 64'(ds));
        chk({tag, " done after last write"}, 64'(done_cyc[i] - last_wr[i]), 64'd1);
        for (int a = 0; a < ds; a++) begin
            written = pad || (a >= 3 && a <= ds - 4);
            expv    = (a < 3) ? 3 : (a > ds - 4) ? ds - 4 : a;
            chk($sformatf("%s wcnt[%0d]", tag, a), 64'(wcnt[i][a]), written ? 64'd1 : 64'd0);
            if (written) chk($sformatf("%s data[%0d]", tag, a), 64'(wval[i][a]), 64'(expv));
        end
    endtask

    task automatic check_lat(input int i, input int s, input string tag);
        chk({tag, " first rd_en latency"}, 64'(first_rd[i] - s), 64'd1);
        chk({tag, " first win_valid latency"}, 64'(first_wv[i] - s), 64'd9);
        chk({tag, " window spacing"}, 64'(second_wv[i] - first_wv[i]), 64'd2);
    endtask

    logic [W*SW-1:0] exp_win;

    initial begin
        int s;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            win_ready[i] = 1'b1;
            clear_sb(i);
        end
        for (int k = 0; k < W; k++) exp_win[k*SW +: SW] = SW'(k + 1);

        repeat (3) @(negedge clk);
        #1;
        check_idle(0, "reset");
        check_idle(1, "reset7");
        @(negedge clk);
        rst = 1'b1;

        // 1: free-running frame
        do_start(0, s);
        #1;
        chk("s1 busy after start", 64'(busy[0]), 64'd1);
        wait_done(0, "s1");
        check_frame(0, 16, "s1");
        check_lat(0, s, "s1");

        // 2: stall the second window for 5 cycles
        clear_sb(0);
        do_start(0, s);
        repeat (10) @(negedge clk);
        win_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("s2 stall win_valid c%0d", k), 64'(win_valid[0]), 64'd1);
            chk($sformatf("s2 stall win_data c%0d", k), 64'(win_data[0]), 64'(exp_win));
            chk($sformatf("s2 stall rd_en c%0d", k), 64'(rd_en[0]), 64'd0);
        end
        @(negedge clk);
        win_ready[0] = 1'b1;
        wait_done(0, "s2");
        check_frame(0, 16, "s2");

        // 3: start in the tenth busy cycle is ignored
        clear_sb(0);
        do_start(0, s);
        repeat (9) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, "s3");
        check_frame(0, 16, "s3");

        // 4: reset after 4 accepts, then a clean frame
        clear_sb(0);
        do_start(0, s);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle(0, "s4 reset");
        clear_sb(0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        do_start(0, s);
        wait_done(0, "s4");
        check_frame(0, 16, "s4");
        check_lat(0, s, "s4");

        // 6: single-window frame
        clear_sb(1);
        do_start(1, s);
        wait_done(1, "s6");
        check_frame(1, 7, "s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
